// File: rtl/morra_pkg.sv
// -----------------------------------------------------------------------------
// morra_pkg
// Shared types for the MorraCinese match driver:
//   move_t    - hand move encoding on PRIMO/SECONDO and the host move pair
//   result_t  - referee MANCHE/PARTITA encoding (also used for "last winner")
//   state_t   - driver FSM states (exposed on the driver's debug port)
//   rotate_move() - next legal move when a winner tries to replay its move
// -----------------------------------------------------------------------------
package morra_pkg;

  typedef enum logic [1:0] {
    MV_NONE    = 2'b00,
    MV_SASSO   = 2'b01,
    MV_CARTA   = 2'b10,
    MV_FORBICE = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    RES_VOID = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_FETCH,
    ST_DRIVE,
    ST_RESULT,
    ST_CLOSE,
    ST_DONE
  } state_t;

  // Rotation order sasso -> carta -> forbice -> sasso; "no move" stays put.
  function automatic move_t rotate_move(input move_t m);
    case (m)
      MV_SASSO:   rotate_move = MV_CARTA;
      MV_CARTA:   rotate_move = MV_FORBICE;
      MV_FORBICE: rotate_move = MV_SASSO;
      default:    rotate_move = MV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/morra_match_driver_if.sv
// -----------------------------------------------------------------------------
// morra_match_driver_if
// Bundles the host move handshake and the referee bus.
//   Host side : mv_valid, mv_ready, mv_p1, mv_p2
//   Referee   : PRIMO, SECONDO, INIZIA (driver -> referee), MANCHE, PARTITA
// Handshake: a move pair transfers on a rising edge where mv_valid && mv_ready
// are both 1. mv_ready never depends combinationally on mv_valid; the host must
// hold mv_p1/mv_p2 stable while mv_valid is 1 and not yet accepted.
// Modports: master = the match driver, slave = host/referee environment.
// -----------------------------------------------------------------------------
interface morra_match_driver_if;
  logic       mv_valid;
  logic       mv_ready;
  logic [1:0] mv_p1;
  logic [1:0] mv_p2;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic       INIZIA;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  modport master (
    input  mv_valid, mv_p1, mv_p2, MANCHE, PARTITA,
    output mv_ready, PRIMO, SECONDO, INIZIA
  );

  modport slave (
    output mv_valid, mv_p1, mv_p2, MANCHE, PARTITA,
    input  mv_ready, PRIMO, SECONDO, INIZIA
  );
endinterface

// File: rtl/morra_rule_guard.sv
// -----------------------------------------------------------------------------
// morra_rule_guard
// Combinational no-repeat rule: the winner of the previous manche may not play
// the move it won with; such a move is rotated to the next one.
// Ports:
//   last_win_i   result_t  previous manche winner (RES_P1/RES_P2, else none)
//   win_move_i   move_t    move the previous winner played
//   p1_i, p2_i   move_t    proposed pair
//   p1_o, p2_o   move_t    legal pair to drive
//   subst_p1_o, subst_p2_o  1 when the corresponding move was rotated
// -----------------------------------------------------------------------------
module morra_rule_guard
  import morra_pkg::*;
(
  input  result_t last_win_i,
  input  move_t   win_move_i,
  input  move_t   p1_i,
  input  move_t   p2_i,
  output move_t   p1_o,
  output move_t   p2_o,
  output logic    subst_p1_o,
  output logic    subst_p2_o
);

  assign subst_p1_o = (last_win_i == RES_P1) && (p1_i == win_move_i) && (p1_i != MV_NONE);
  assign subst_p2_o = (last_win_i == RES_P2) && (p2_i == win_move_i) && (p2_i != MV_NONE);

  assign p1_o = subst_p1_o ? rotate_move(p1_i) : p1_i;
  assign p2_o = subst_p2_o ? rotate_move(p2_i) : p2_i;

endmodule

// File: rtl/morra_match_driver.sv
// -----------------------------------------------------------------------------
// morra_match_driver
// Player-side initiator for the MorraCinese referee. Sends one configuration
// cycle (INIZIA with the match count on PRIMO/SECONDO), then plays manches from
// host move pairs until the configured number of matches is over, enforcing the
// no-repeat rule and keeping match tallies.
// Optional build macro: MORRA_AUTOPLAY_EN - moves come from an 8-bit LFSR
// (seed LFSR_SEED) instead of the host handshake; mv_ready stays 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             session start pulse (honoured in IDLE only)
//   cfg_partite       matches per session, 0 treated as 1
//   bus               morra_match_driver_if.master (host handshake + referee)
//   busy, done        session active / session complete (done held until start)
//   wins_p1, wins_p2  matches won per player (saturating)
//   subst_cnt         moves rotated by the no-repeat rule (saturating)
//   state_o, manche_cnt_o, matches_played_o, last_win_o  debug observation
// -----------------------------------------------------------------------------
module morra_match_driver
  import morra_pkg::*;
#(
  parameter int MAX_MANCHE = 19,
  parameter int CNT_W      = 5
`ifdef MORRA_AUTOPLAY_EN
  , parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            cfg_partite,
  morra_match_driver_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      wins_p1,
  output logic [CNT_W-1:0]      wins_p2,
  output logic [CNT_W-1:0]      subst_cnt,
  output state_t                state_o,
  output logic [CNT_W-1:0]      manche_cnt_o,
  output logic [CNT_W-1:0]      matches_played_o,
  output result_t               last_win_o
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] MANCHE_LIMIT = CNT_W'(MAX_MANCHE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q;
  move_t            primo_q, secondo_q, drv_p1_q, drv_p2_q, win_move_q;
  logic             inizia_q, mv_ready_q, busy_q, done_q;
  logic [CNT_W-1:0] wins_p1_q, wins_p2_q, subst_q, manche_q, played_q, cfg_q;
  result_t          last_win_q, partita_q;

  move_t            src_p1, src_p2, legal_p1, legal_p2;
  logic             subst_p1, subst_p2, xfer;
  result_t          manche_res, partita_res;
  logic [CNT_W-1:0] manche_d, played_d;
  logic             close_now, session_over;

`ifdef MORRA_AUTOPLAY_EN
  localparam logic READY_EN = 1'b0;
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, advanced once per drawn pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= LFSR_SEED;
    else if (xfer) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign xfer   = (state_q == ST_FETCH);
  assign src_p1 = (lfsr_q[1:0] == 2'b00) ? MV_SASSO : move_t'(lfsr_q[1:0]);
  assign src_p2 = (lfsr_q[3:2] == 2'b00) ? MV_SASSO : move_t'(lfsr_q[3:2]);
`else
  localparam logic READY_EN = 1'b1;

  assign xfer   = (state_q == ST_FETCH) && bus.mv_valid && mv_ready_q;
  assign src_p1 = move_t'(bus.mv_p1);
  assign src_p2 = move_t'(bus.mv_p2);
`endif

  morra_rule_guard u_guard (
    .last_win_i (last_win_q),
    .win_move_i (win_move_q),
    .p1_i       (src_p1),
    .p2_i       (src_p2),
    .p1_o       (legal_p1),
    .p2_o       (legal_p2),
    .subst_p1_o (subst_p1),
    .subst_p2_o (subst_p2)
  );

  assign manche_res   = result_t'(bus.MANCHE);
  assign partita_res  = result_t'(bus.PARTITA);
  // Void manches are not counted and never close a match.
  assign manche_d     = (manche_res != RES_VOID) ? sat_inc(manche_q) : manche_q;
  assign close_now    = (partita_res != RES_VOID) || (manche_d == MANCHE_LIMIT);
  assign played_d     = sat_inc(played_q);
  assign session_over = (played_d >= cfg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      primo_q    <= MV_NONE;
      secondo_q  <= MV_NONE;
      drv_p1_q   <= MV_NONE;
      drv_p2_q   <= MV_NONE;
      win_move_q <= MV_NONE;
      inizia_q   <= 1'b0;
      mv_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wins_p1_q  <= '0;
      wins_p2_q  <= '0;
      subst_q    <= '0;
      manche_q   <= '0;
      played_q   <= '0;
      cfg_q      <= '0;
      last_win_q <= RES_VOID;
      partita_q  <= RES_VOID;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_CONFIG;
            inizia_q   <= 1'b1;
            primo_q    <= move_t'(cfg_partite[3:2]);
            secondo_q  <= move_t'(cfg_partite[1:0]);
            cfg_q      <= (cfg_partite == 4'd0) ? CNT_W'(1) : CNT_W'(cfg_partite);
            wins_p1_q  <= '0;
            wins_p2_q  <= '0;
            subst_q    <= '0;
            manche_q   <= '0;
            played_q   <= '0;
            last_win_q <= RES_VOID;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_CONFIG: begin
          state_q    <= ST_FETCH;
          inizia_q   <= 1'b0;
          primo_q    <= MV_NONE;
          secondo_q  <= MV_NONE;
          mv_ready_q <= READY_EN;
        end
        ST_FETCH: begin
          if (xfer) begin
            state_q    <= ST_DRIVE;
            mv_ready_q <= 1'b0;
            primo_q    <= legal_p1;
            secondo_q  <= legal_p2;
            drv_p1_q   <= legal_p1;
            drv_p2_q   <= legal_p2;
            if (subst_p1 || subst_p2) subst_q <= sat_inc(subst_q);
          end
        end
        ST_DRIVE: begin
          state_q   <= ST_RESULT;
          primo_q   <= MV_NONE;
          secondo_q <= MV_NONE;
        end
        ST_RESULT: begin
          manche_q  <= manche_d;
          partita_q <= partita_res;
          case (manche_res)
            RES_P1: begin
              last_win_q <= RES_P1;
              win_move_q <= drv_p1_q;
            end
            RES_P2: begin
              last_win_q <= RES_P2;
              win_move_q <= drv_p2_q;
            end
            RES_DRAW: last_win_q <= RES_VOID;
            default: ;
          endcase
          if (close_now) begin
            state_q <= ST_CLOSE;
          end else begin
            state_q    <= ST_FETCH;
            mv_ready_q <= READY_EN;
          end
        end
        ST_CLOSE: begin
          played_q <= played_d;
          if (partita_q == RES_P1) wins_p1_q <= sat_inc(wins_p1_q);
          if (partita_q == RES_P2) wins_p2_q <= sat_inc(wins_p2_q);
          if (session_over) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            // Next match starts without a new configuration cycle.
            state_q    <= ST_FETCH;
            manche_q   <= '0;
            last_win_q <= RES_VOID;
            mv_ready_q <= READY_EN;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.PRIMO        = primo_q;
  assign bus.SECONDO      = secondo_q;
  assign bus.INIZIA       = inizia_q;
  assign bus.mv_ready     = mv_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign wins_p1          = wins_p1_q;
  assign wins_p2          = wins_p2_q;
  assign subst_cnt        = subst_q;
  assign state_o          = state_q;
  assign manche_cnt_o     = manche_q;
  assign matches_played_o = played_q;
  assign last_win_o       = last_win_q;

endmodule

// File: tb/tb_morra_match_driver.sv
// -----------------------------------------------------------------------------
// tb_morra_match_driver
// Directed bench for morra_match_driver. The bench plays host and referee.
// Every move pair sent is paired with the pair the driver must put on
// PRIMO/SECONDO (after the no-repeat rule); a monitor compares it during DRIVE.
// -----------------------------------------------------------------------------
module tb_morra_match_driver;
  import morra_pkg::*;

  localparam int CNT_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start;
  logic [3:0]       cfg_partite;
  logic             busy, done;
  logic [CNT_W-1:0] wins_p1, wins_p2, subst_cnt, manche_cnt, matches_played;
  state_t           state;
  result_t          last_win;

  morra_match_driver_if bus();

  morra_match_driver #(.MAX_MANCHE(19), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cfg_partite      (cfg_partite),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .wins_p1          (wins_p1),
    .wins_p2          (wins_p2),
    .subst_cnt        (subst_cnt),
    .state_o          (state),
    .manche_cnt_o     (manche_cnt),
    .matches_played_o (matches_played),
    .last_win_o       (last_win)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whatever the driver presents during DRIVE must be the next expected pair.
  always @(negedge clk) begin
    if (rst_n && state == ST_DRIVE) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_unexpected: got %b/%b with no pair expected", bus.PRIMO, bus.SECONDO);
      end else begin
        check("drive_pair", {28'd0, bus.PRIMO, bus.SECONDO}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic start_session(input logic [3:0] cfg);
    cfg_partite = cfg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.mv_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.mv_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: mv_ready still 0 after %0d cycles, needed 1", n);
    end
  endtask

  task automatic xfer(input logic [1:0] p1, input logic [1:0] p2);
    wait_ready();
    bus.mv_valid = 1'b1;
    bus.mv_p1    = p1;
    bus.mv_p2    = p2;
    @(posedge clk); #1;
    bus.mv_valid = 1'b0;
    bus.mv_p1    = 2'b00;
    bus.mv_p2    = 2'b00;
  endtask

  // Referee answer held through DRIVE and RESULT, then released.
  task automatic referee(input logic [1:0] m, input logic [1:0] pt);
    bus.MANCHE  = m;
    bus.PARTITA = pt;
    @(posedge clk);
    @(posedge clk); #1;
    bus.MANCHE  = 2'b00;
    bus.PARTITA = 2'b00;
  endtask

  task automatic play(input logic [1:0] p1, input logic [1:0] p2,
                      input logic [1:0] e1, input logic [1:0] e2,
                      input logic [1:0] m,  input logic [1:0] pt);
    exp_q.push_back({e1, e2});
    xfer(p1, p2);
    referee(m, pt);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_partite = 4'd0;
    bus.mv_valid = 1'b0;
    bus.mv_p1 = 2'b00;
    bus.mv_p2 = 2'b00;
    bus.MANCHE = 2'b00;
    bus.PARTITA = 2'b00;
    @(posedge clk); @(posedge clk); #1;

    // Reset values
    check("rst_state", state, ST_IDLE);
    check("rst_primo", bus.PRIMO, 2'b00);
    check("rst_secondo", bus.SECONDO, 2'b00);
    check("rst_inizia", bus.INIZIA, 1'b0);
    check("rst_ready", bus.mv_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wins", {wins_p1, wins_p2, subst_cnt}, 15'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Configuration cycle, then abort with reset while in DRIVE
    start_session(4'b0110);
    check("cfg_inizia", bus.INIZIA, 1'b1);
    check("cfg_primo", bus.PRIMO, 2'b01);
    check("cfg_secondo", bus.SECONDO, 2'b10);
    check("cfg_busy", busy, 1'b1);
    check("cfg_ready", bus.mv_ready, 1'b0);
    @(posedge clk); #1;
    check("post_cfg_inizia", bus.INIZIA, 1'b0);
    check("post_cfg_moves", {bus.PRIMO, bus.SECONDO}, 4'b0000);
    check("first_ready", bus.mv_ready, 1'b1);
    play(2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00);   // P1 wins with carta
    check("a_manche_cnt", manche_cnt, 5'd1);
    exp_q.push_back(4'b1111);                          // carta repeated -> forbice
    xfer(2'b10, 2'b11);
    check("a_state_drive", state, ST_DRIVE);
    check("a_subst", subst_cnt, 5'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_moves", {bus.PRIMO, bus.SECONDO}, 4'b0000);
    check("arst_inizia", bus.INIZIA, 1'b0);
    check("arst_state", state, ST_IDLE);
    check("arst_busy", busy, 1'b0);
    check("arst_cnts", {subst_cnt, manche_cnt, matches_played}, 15'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Session of 2 matches: substitution, void manches, both players win once
    start_session(4'd2);
    check("b_cfg_moves", {bus.PRIMO, bus.SECONDO}, 4'b0010);
    play(2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00);   // P1 wins with sasso
    play(2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00);   // sasso rotated, draw
    check("b_subst1", subst_cnt, 5'd1);
    check("b_manche2", manche_cnt, 5'd2);
    check("b_lastwin_draw", last_win, RES_VOID);
    play(2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01);   // P1 takes match 1
    check("b_close_state", state, ST_CLOSE);
    @(posedge clk); #1;
    check("b_m1_state", state, ST_FETCH);
    check("b_m1_wins_p1", wins_p1, 5'd1);
    check("b_m1_played", matches_played, 5'd1);
    check("b_m1_manche", manche_cnt, 5'd0);
    check("b_m1_busy", busy, 1'b1);
    play(2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00);   // P2 wins with carta
    for (int i = 0; i < 3; i++) begin
      play(2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00); // void manche
      check("b_void_ready", bus.mv_ready, 1'b1);
    end
    check("b_void_manche", manche_cnt, 5'd1);
    check("b_void_lastwin", last_win, RES_P2);
    play(2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10);   // carta rotated, P2 takes match 2
    check("b_subst2", subst_cnt, 5'd2);
    @(posedge clk); #1;
    check("b_done_state", state, ST_DONE);
    check("b_done", done, 1'b1);
    check("b_done_busy", busy, 1'b0);
    check("b_done_ready", bus.mv_ready, 1'b0);
    check("b_wins", {wins_p1, wins_p2}, {5'd1, 5'd1});
    check("b_played", matches_played, 5'd2);
    @(posedge clk); #1;
    check("b_idle_state", state, ST_IDLE);
    check("b_idle_done", done, 1'b1);

    // Single match won by P2 through PARTITA
    start_session(4'd1);
    check("c_cfg_done", done, 1'b0);
    play(2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10);
    @(posedge clk); #1;
    check("c_wins_p2", wins_p2, 5'd1);
    check("c_wins_p1", wins_p1, 5'd0);
    check("c_done", done, 1'b1);
    check("c_busy", busy, 1'b0);
    check("c_ready", bus.mv_ready, 1'b0);
    @(posedge clk); #1;

    // cfg 0 (one match) closed by 19 draws; start while busy is ignored
    start_session(4'd0);
    play(2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00);
    start_session(4'd5);
    check("d_start_ignored", state, ST_FETCH);
    check("d_no_inizia", bus.INIZIA, 1'b0);
    for (int i = 0; i < 17; i++)
      play(2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00);
    check("d_manche18", manche_cnt, 5'd18);
    check("d_open18", state, ST_FETCH);
    play(2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00);
    check("d_close19", state, ST_CLOSE);
    @(posedge clk); #1;
    check("d_done", done, 1'b1);
    check("d_played", matches_played, 5'd1);
    check("d_wins", {wins_p1, wins_p2}, 10'd0);
    @(posedge clk); #1;

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
